// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding buffer.
// Emits one bit per enabled cycle, with zero-bubble word chaining.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             bit_en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] sh_data_q, sh_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;
  logic             drain;
  logic [WIDTH-1:0] sh_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      sh_data_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      sh_data_q   <= sh_data_d;
      cnt_q       <= cnt_d;
    end
  end

  // Shift toward whichever end drives bit_out.
  always_comb begin
    sh_next = '0;
    if (MSB_FIRST) sh_next = {sh_data_q[WIDTH-2:0], 1'b0};
    else           sh_next = {1'b0, sh_data_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    sh_data_d = sh_data_q;
    cnt_d     = cnt_q;
    drain     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          sh_data_d = hold_data_q;
          cnt_d     = '0;
          drain     = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (hold_full_q) begin
              sh_data_d = hold_data_q;
              drain     = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            sh_data_d = sh_next;
            cnt_d     = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A write needs an empty buffer and a drain a full one, so they never coincide.
  assign accept = data_valid && !hold_full_q;

  always_comb begin
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_data_d = data_in;
      hold_full_d = 1'b1;
    end else if (drain) begin
      hold_full_d = 1'b0;
    end
  end

  assign data_ready = !hold_full_q;
  assign bit_valid  = (state_q == SHIFT) && bit_en;
  assign last_bit   = bit_valid && (cnt_q == CNT_LAST);
  assign busy       = (state_q == SHIFT) || hold_full_q;
  assign bit_out    = (state_q == SHIFT)
                    ? (MSB_FIRST ? sh_data_q[WIDTH-1] : sh_data_q[0])
                    : IDLE_BIT;

endmodule

// File: tb/tb_bit_serializer.sv
// Randomised and directed bench for bit_serializer; an MSB-first and an LSB-first
// instance share stimulus and are checked against a word-queue reference model.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         bit_en;
  logic         ready_m, bout_m, bval_m, last_m, busy_m;
  logic         ready_l, bout_l, bval_l, last_l, busy_l;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready_m), .bit_en(bit_en), .bit_out(bout_m),
    .bit_valid(bval_m), .last_bit(last_m), .busy(busy_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready_l), .bit_en(bit_en), .bit_out(bout_l),
    .bit_valid(bval_l), .last_bit(last_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: words waiting in the buffer, plus the word being emitted.
  logic [W-1:0] held[$];
  logic [W-1:0] cur;
  int unsigned  idx;
  bit           active;

  logic [W-1:0] cap_m, cap_l;
  int unsigned  nvalid;
  bit           acc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    held.delete();
    active = 1'b0;
    idx    = 0;
    cur    = '0;
  endtask

  // Compare every output against the model at the negedge, then advance the model over the posedge.
  task automatic step();
    bit   m_ready, m_valid, m_last;
    logic m_bm, m_bl;
    @(negedge clk);
    m_ready = (held.size() == 0);
    m_valid = active && bit_en;
    m_last  = m_valid && (idx == W - 1);
    m_bm    = active ? cur[W-1-idx] : 1'b0;
    m_bl    = active ? cur[idx] : 1'b0;
    check_eq("ready_m", ready_m, m_ready);
    check_eq("ready_l", ready_l, m_ready);
    check_eq("bval_m", bval_m, m_valid);
    check_eq("bval_l", bval_l, m_valid);
    check_eq("last_m", last_m, m_last);
    check_eq("last_l", last_l, m_last);
    check_eq("busy_m", busy_m, active || !m_ready);
    check_eq("busy_l", busy_l, active || !m_ready);
    check_eq("bout_m", bout_m, m_bm);
    check_eq("bout_l", bout_l, m_bl);
    if (bval_m) begin
      cap_m = {cap_m[W-2:0], bout_m};
      nvalid++;
    end
    if (bval_l) cap_l = {cap_l[W-2:0], bout_l};
    @(posedge clk);
    acc = data_valid && m_ready;
    if (active && bit_en) begin
      if (idx == W - 1) begin
        idx = 0;
        if (held.size() != 0) cur = held.pop_front();
        else                  active = 1'b0;
      end else begin
        idx++;
      end
    end else if (!active && held.size() != 0) begin
      cur    = held.pop_front();
      active = 1'b1;
      idx    = 0;
    end
    if (acc) held.push_back(data_in);
    #1;
  endtask

  // Offer a word and leave data_valid high after it is taken.
  task automatic send(input logic [W-1:0] w);
    int unsigned n;
    data_in    = w;
    data_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      step();
      n++;
    end
    check_eq("send_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic drain();
    int unsigned n;
    data_valid = 1'b0;
    bit_en     = 1'b1;
    n = 0;
    while ((active || held.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check_eq("drain_done", {31'd0, active || held.size() != 0}, 32'd0);
    step();
  endtask

  initial begin
    int unsigned base;
    rst_n      = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    bit_en     = 1'b0;
    cap_m      = '0;
    cap_l      = '0;
    nvalid     = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    repeat (3) step();

    // Single word, continuous strobe.
    bit_en = 1'b1;
    base   = nvalid;
    send(8'hB0);
    drain();
    check_eq("t1_bits_msb", {24'd0, cap_m}, 32'hB0);
    check_eq("t1_count", nvalid - base, 32'd8);

    // Back-to-back words with valid held high.
    base = nvalid;
    send(8'hB0);
    send(8'h0B);
    drain();
    check_eq("t2_last_word", {24'd0, cap_m}, 32'h0B);
    check_eq("t2_count", nvalid - base, 32'd16);

    // LSB-first ordering.
    send(8'h0D);
    drain();
    check_eq("t3_bits_lsb", {24'd0, cap_l}, 32'hB0);

    // Strobe one cycle in three.
    base = nvalid;
    data_in    = 8'hA5;
    data_valid = 1'b1;
    bit_en     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bit_en = (i % 3 == 2);
      step();
      if (acc) data_valid = 1'b0;
    end
    drain();
    check_eq("t4_bits", {24'd0, cap_m}, 32'hA5);
    check_eq("t4_count", nvalid - base, 32'd8);

    // Backpressure: second word held off while the buffer is occupied.
    bit_en = 1'b1;
    base   = nvalid;
    send(8'h11);
    send(8'h22);
    data_in = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t5_ready_low", {31'd0, ready_m}, 32'd0);
    end
    send(8'h3C);
    drain();
    check_eq("t5_last_word", {24'd0, cap_m}, 32'h3C);
    check_eq("t5_count", nvalid - base, 32'd24);

    // Reset mid-frame discards the partial and held words.
    base = nvalid;
    send(8'hFF);
    send(8'h00);
    data_valid = 1'b0;
    for (int i = 0; i < 20 && (nvalid - base) < 3; i++) step();
    rst_n = 1'b0;
    #1;
    check_eq("t6_bval", {31'd0, bval_m}, 32'd0);
    check_eq("t6_busy", {31'd0, busy_m}, 32'd0);
    check_eq("t6_ready", {31'd0, ready_m}, 32'd1);
    check_eq("t6_bout", {31'd0, bout_m}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    base = nvalid;
    repeat (12) step();
    check_eq("t6_no_bits", nvalid - base, 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      data_in    = W'($urandom);
      data_valid = ($urandom_range(0, 3) != 0);
      bit_en     = ($urandom_range(0, 4) != 0);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
